// File: rtl/edge_event_queue.sv
// edge_event_queue
//   Captures one-cycle rising-edge pulses into per-source pending flags,
//   round-robin arbitrates among them and queues the granted source index
//   in a small FIFO drained with a valid/ready handshake. A pulse arriving on
//   a source that still has an unserved pending event is merged and flagged
//   in a sticky per-source overrun register.
//
//   Optional feature macro: EDGE_EVENT_QUEUE_TIMESTAMP_EN
//     When defined, a free-running TS_W-bit counter is sampled into a
//     per-source capture register when that source goes pending, and the
//     capture travels through the FIFO alongside the index (evt_ts port).
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   pedge      : W one-cycle event pulses, bit i = event on source i
//   evt_valid  : FIFO head holds an event
//   evt_ready  : consumer accepts the head when evt_valid && evt_ready
//   evt_id     : source index of the head event, 0 when empty
//   evt_ts     : timestamp of the head event, 0 when empty (feature only)
//   ovf        : sticky per-source overrun flags
//   ovf_clr    : clears all overrun flags (a same-cycle set wins)
//   fifo_count : FIFO occupancy, 0..DEPTH
module edge_event_queue #(
  parameter int W     = 8,
  parameter int ID_W  = $clog2(W),
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     pedge,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
`ifdef EDGE_EVENT_QUEUE_TIMESTAMP_EN
  output logic [TS_W-1:0]  evt_ts,
`endif
  output logic [W-1:0]     ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef EDGE_EVENT_QUEUE_TIMESTAMP_EN
  localparam int ENT_W = TS_W + ID_W;
`else
  localparam int ENT_W = ID_W;
`endif
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     pending_q, pending_d;
  logic [W-1:0]     ovf_q, ovf_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic             pop, push_ok;
  logic             sel_vld, grant_vld;
  logic [ID_W-1:0]  sel_idx, cand_idx;
  logic [W-1:0]     grant_vec, ovf_set;
  logic [ENT_W-1:0] push_entry, head;
  int               cand;

`ifdef EDGE_EVENT_QUEUE_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  ts_cap_q [W];
`endif

  assign pop     = (count_q != '0) && evt_ready;
  // A full FIFO can still accept a push when the head leaves on the same edge.
  assign push_ok = (count_q != FULL_CNT) || pop;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= W; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= W) cand = cand - W;
      cand_idx = ID_W'(cand);
      if (!sel_vld && pending_q[cand_idx]) begin
        sel_vld = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  assign grant_vld = sel_vld && push_ok;

  always_comb begin
    grant_vec = '0;
    if (grant_vld) grant_vec[sel_idx] = 1'b1;
  end

  // A new pulse always wins over the clearing grant, so nothing is dropped.
  assign pending_d = pedge | (pending_q & ~grant_vec);
  assign ovf_set   = pedge & pending_q & ~grant_vec;
  assign ovf_d     = (ovf_clr ? '0 : ovf_q) | ovf_set;
  assign rr_ptr_d  = grant_vld ? sel_idx : rr_ptr_q;
  assign count_d   = count_q + CNT_W'(grant_vld) - CNT_W'(pop);

`ifdef EDGE_EVENT_QUEUE_TIMESTAMP_EN
  assign push_entry = {ts_cap_q[sel_idx], sel_idx};
`else
  assign push_entry = sel_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      ovf_q     <= '0;
      rr_ptr_q  <= ID_W'(W - 1);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
      if (grant_vld) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage is data only; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (grant_vld) mem_q[wr_ptr_q] <= push_entry;
  end

`ifdef EDGE_EVENT_QUEUE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end

  // Only a fresh event records its time; a merged pulse keeps the original.
  always_ff @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (pedge[i] && !pending_q[i]) ts_cap_q[i] <= ts_q;
    end
  end
`endif

  assign head       = mem_q[rd_ptr_q];
  assign evt_valid  = (count_q != '0);
  assign evt_id     = evt_valid ? head[ID_W-1:0] : '0;
`ifdef EDGE_EVENT_QUEUE_TIMESTAMP_EN
  assign evt_ts     = evt_valid ? head[ENT_W-1:ID_W] : '0;
`endif
  assign ovf        = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: doc/edge_event_queue.md
Name: edge_event_queue

Overview:
- Downstream consumer of the 8-bit rising-edge pulse vector produced by the edge-detect stage.
- Latches each one-cycle pulse into a per-bit pending flag and round-robin arbitrates among the pending flags.
- Encodes each granted bit as an event ID and pushes it into a small FIFO drained via a valid/ready handshake.
- Flags per-bit overruns so that no event is lost silently.

Parameters:
- W, 8, number of pulse inputs (>=2).
- ID_W, $clog2(W), event ID width (derived; do not override).
- DEPTH, 4, FIFO entries; power of 2, >=2.
- CNT_W, $clog2(DEPTH)+1, fifo_count width (derived).
- TS_W, 16, timestamp width (used only with TIMESTAMP_EN).

Ports:
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  reset, synchronous, active-high.
- pedge  in  W  one-cycle event pulses from the upstream edge detector; bit i = event on source i.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head on a cycle where evt_valid&&evt_ready.
- evt_id  out  ID_W  source index of the head event; 0 when the FIFO is empty.
- evt_ts  out  TS_W  timestamp of the head event (present only with TIMESTAMP_EN).
- ovf  out  W  sticky per-bit overrun flags.
- ovf_clr  in  1  clears all ovf bits.
- fifo_count  out  CNT_W  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at clk edge): pending=0, ovf=0, FIFO empty, evt_valid=0, evt_id=0, fifo_count=0, rr_ptr=W-1 (bit 0 has highest priority first), timestamp counter=0. Reset mid-operation discards all pending and queued events and drops any in-flight handshake.
- Pending register, per bit i, in priority order:
  - pedge[i]=1 -> pending[i]<=1.
  - else grant[i]=1 -> pending[i]<=0.
  - else hold.
  - pedge[i] on the same cycle as grant[i]: pending stays 1 (new event kept, no loss).
- Overrun: pedge[i]=1 while pending[i]=1 and grant[i]=0 -> event merged, ovf[i]<=1.
  - ovf_clr=1: ovf<=0, except a bit being set on that same cycle, where set wins.
  - ovf never clears otherwise.
- Arbiter (combinational on registered pending):
  - Grants at most one bit per cycle.
  - Searches from (rr_ptr+1) mod W upward with wrap.
  - Grants only when push_ok = (fifo_count<DEPTH) || (fifo_count==DEPTH && evt_valid && evt_ready).
  - On grant, rr_ptr<=granted index; otherwise rr_ptr holds.
- FIFO:
  - A grant pushes its index at the same clk edge.
  - Pop occurs when evt_valid && evt_ready.
  - Push and pop on the same cycle are legal at any occupancy; count is unchanged.
  - evt_valid = (fifo_count!=0); outputs are the head entry.
  - Read/write pointers wrap mod DEPTH.
  - Overflow and underflow are impossible by construction; evt_ready while empty is ignored.
- Latency, empty queue, no contention: pedge[i] high in cycle N -> pending[i]=1 in N+1 -> granted in N+1 -> evt_valid=1 with evt_id=i in N+2.
- Back-pressure: with FIFO full and evt_ready=0, pending bits hold and further pulses on those bits set ovf. Pulses on non-pending bits are still captured as pending.
- Output stability: while evt_valid=1 and evt_ready=0, evt_id (and evt_ts) hold stable.

Optional Feature:
- Macro: EDGE_EVENT_QUEUE_TIMESTAMP_EN.
- Defined:
  - Free-running TS_W-bit counter increments every cycle after reset and wraps 2^TS_W-1 -> 0.
  - Per-bit ts_capture[i] loads the counter value on a cycle where pedge[i] sets pending[i] from 0.
  - A merged pulse does not update ts_capture[i].
  - The FIFO entry is {ts_capture[i], i}, and evt_ts outputs the head timestamp.
  - evt_ts=0 when empty.
- Undefined: no counter, no capture registers, no evt_ts port; FIFO is ID_W wide.

Test Plan:
- Reset, then pedge=8'h04 for 1 cycle at N, evt_ready=1 -> evt_valid=1, evt_id=2 at N+2 only; fifo_count back to 0 at N+3; ovf=0.
- pedge=8'h81 in one cycle, evt_ready=1 -> events out in order id 0, then id 7, on consecutive cycles. Then pedge=8'h81 again -> id 0, then 7, since rr_ptr=7 wraps to 0 first.
- evt_ready=0, pulse bits 0,1,2,3,4 once each -> fifo_count=4 holding ids 0,1,2,3; pending=8'h10. Pulse bit 4 again -> ovf=8'h10. Raise evt_ready -> ids 0,1,2,3,4 drained, fifo_count 0.
- FIFO full, evt_ready=1 steadily, with pending bit 5 -> same-cycle push/pop, fifo_count stays 4, id 5 queued.
- pedge[3] on the grant cycle of bit 3 -> two id-3 events emitted, ovf[3]=0. Then ovf_clr with a concurrent overrun on bit 6 -> ovf=8'h40.
- With TIMESTAMP_EN: counter preset near 16'hFFFE, pulse bit 1 at counter FFFF and bit 2 at 0000 -> evt_ts FFFF then 0000. rst asserted with 3 queued events -> next cycle evt_valid=0, fifo_count=0, ovf=0.
